// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART frame receiver.
// Holds the deframer state encoding and the checksum arithmetic.
package uart_pkg;

  typedef enum logic [2:0] {
    HUNT,
    LEN,
    DATA,
    CHK,
    DRAIN
  } frame_state_e;

  localparam logic [7:0] SOF_DEFAULT = 8'h7E;

  // Running checksum: plain 8-bit two's-complement sum.
  function automatic logic [7:0] chk_add(
    input logic [7:0] a,
    input logic [7:0] b
  );
    return a + b;
  endfunction

endpackage

// File: rtl/uart_frame_buf.sv
// Payload buffer for the frame receiver.
// Synchronous write, combinational read, contents never reset.
module uart_frame_buf #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);

  logic [7:0] mem [DEPTH];

  // Store one payload byte per write strobe.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/uart_frame_rx.sv
// Deframer for SOF/LEN/payload/CHK packets from the UART receiver.
// Releases the payload only after the checksum has been verified.
module uart_frame_rx
  import uart_pkg::*;
#(
  parameter logic [7:0]  SOF     = SOF_DEFAULT,
  parameter int          MAX_LEN = 16,
  parameter logic [15:0] TIMEOUT = 16'd5000
) (
  input  logic       _clock,
  input  logic       _reset,
  input  logic [7:0] _in,
  input  logic       _in_valid,
  output logic       _in_ready,
  output logic [7:0] _out,
  output logic       _out_valid,
  input  logic       _out_ready,
  output logic       _out_last,
  output logic       _err_len,
  output logic       _err_chk,
  output logic       _err_timeout,
  output logic       _err_overrun
);

  localparam int         AW    = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [7:0] MAXL8 = 8'(MAX_LEN);

  frame_state_e state_q, state_d;
  logic [7:0]   len_q, len_d;
  logic [7:0]   index_q, index_d;
  logic [7:0]   sum_q, sum_d;
  logic [15:0]  gap_q, gap_d;
  logic         e_len_d, e_chk_d, e_tmo_d, e_ovr_d;
  logic         we;
  logic [7:0]   rdata;
  logic         accept, draining, last, counting;

  assign draining = (state_q == DRAIN);
  assign accept   = _in_valid && !draining;
  assign last     = (index_q == len_q - 8'd1);
  assign counting = (state_q == LEN) || (state_q == DATA) ||
                    (state_q == CHK);

  assign _in_ready  = !draining;
  assign _out_valid = draining;
  assign _out       = draining ? rdata : 8'h00;
  assign _out_last  = draining && last;

  uart_frame_buf #(
    .DEPTH (MAX_LEN),
    .AW    (AW)
  ) u_buf (
    .clk   (_clock),
    .we    (we),
    .waddr (index_q[AW-1:0]),
    .wdata (_in),
    .raddr (index_q[AW-1:0]),
    .rdata (rdata)
  );

  // State, counters and registered error pulses.
  always_ff @(posedge _clock or negedge _reset) begin
    if (!_reset) begin
      state_q      <= HUNT;
      len_q        <= 8'h00;
      index_q      <= 8'h00;
      sum_q        <= 8'h00;
      gap_q        <= 16'h0000;
      _err_len     <= 1'b0;
      _err_chk     <= 1'b0;
      _err_timeout <= 1'b0;
      _err_overrun <= 1'b0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      index_q      <= index_d;
      sum_q        <= sum_d;
      gap_q        <= gap_d;
      _err_len     <= e_len_d;
      _err_chk     <= e_chk_d;
      _err_timeout <= e_tmo_d;
      _err_overrun <= e_ovr_d;
    end
  end

  // Next-state: byte parsing, drain handshake and inter-byte timeout.
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    index_d = index_q;
    sum_d   = sum_q;
    gap_d   = gap_q;
    e_len_d = 1'b0;
    e_chk_d = 1'b0;
    e_tmo_d = 1'b0;
    e_ovr_d = 1'b0;
    we      = 1'b0;
    unique case (state_q)
      HUNT: begin
        if (accept && _in == SOF) begin
          state_d = LEN;
          sum_d   = 8'h00;
          gap_d   = 16'h0000;
        end
      end
      LEN: begin
        if (accept) begin
          gap_d = 16'h0000;
          if (_in == 8'h00 || _in > MAXL8) begin
            e_len_d = 1'b1;
            state_d = HUNT;
          end else begin
            len_d   = _in;
            sum_d   = _in;
            index_d = 8'h00;
            state_d = DATA;
          end
        end
      end
      DATA: begin
        if (accept) begin
          we      = 1'b1;
          gap_d   = 16'h0000;
          sum_d   = chk_add(sum_q, _in);
          index_d = index_q + 8'd1;
          if (last) state_d = CHK;
        end
      end
      CHK: begin
        if (accept) begin
          gap_d = 16'h0000;
          if (chk_add(sum_q, _in) == 8'h00) begin
            index_d = 8'h00;
            state_d = DRAIN;
          end else begin
            e_chk_d = 1'b1;
            state_d = HUNT;
          end
        end
      end
      DRAIN: begin
        e_ovr_d = _in_valid;
        if (_out_ready) begin
          if (last) begin
            index_d = 8'h00;
            state_d = HUNT;
          end else begin
            index_d = index_q + 8'd1;
          end
        end
      end
      default: state_d = HUNT;
    endcase
    // An arriving byte always beats the timeout in the same cycle.
    if (counting && !accept) begin
      if (gap_q != 16'hFFFF) gap_d = gap_q + 16'd1;
      if (gap_q + 16'd1 == TIMEOUT) begin
        e_tmo_d = 1'b1;
        state_d = HUNT;
      end
    end
  end

endmodule

// File: tb/tb_uart_frame_rx.sv
// Directed bench for uart_frame_rx.
// Each scenario task drives frames and checks its own results.
module tb_uart_frame_rx;

  localparam int T = 5000;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] in_byte = 8'h00;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] out_byte;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic       out_last;
  logic       err_len, err_chk, err_timeout, err_overrun;

  int vec = 0;
  int miss = 0;
  int cyc = 0;
  int n_len = 0, n_chk = 0, n_tmo = 0, n_ovr = 0, n_multi = 0;
  logic [7:0] got_b [$];
  logic       got_l [$];
  int         got_c [$];
  logic [7:0] tx [$];

  uart_frame_rx dut (
    ._clock       (clk),
    ._reset       (rst_n),
    ._in          (in_byte),
    ._in_valid    (in_valid),
    ._in_ready    (in_ready),
    ._out         (out_byte),
    ._out_valid   (out_valid),
    ._out_ready   (out_ready),
    ._out_last    (out_last),
    ._err_len     (err_len),
    ._err_chk     (err_chk),
    ._err_timeout (err_timeout),
    ._err_overrun (err_overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && out_ready) begin
        got_b.push_back(out_byte);
        got_l.push_back(out_last);
        got_c.push_back(cyc);
      end
      n_len += int'(err_len);
      n_chk += int'(err_chk);
      n_tmo += int'(err_timeout);
      n_ovr += int'(err_overrun);
      if (int'(err_len) + int'(err_chk) + int'(err_timeout) +
          int'(err_overrun) > 1) n_multi++;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic clr();
    got_b.delete();
    got_l.delete();
    got_c.delete();
    n_len = 0;
    n_chk = 0;
    n_tmo = 0;
    n_ovr = 0;
  endtask

  task automatic send_q();
    foreach (tx[i]) begin
      @(posedge clk);
      #1;
      in_byte  = tx[i];
      in_valid = 1'b1;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    tx.delete();
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_drain();
    int k;
    for (k = 0; k < 100; k++) begin
      @(negedge clk);
      if (!out_valid) break;
    end
    vec++;
    if (k == 100) begin
      miss++;
      $display("FAIL drain_end: got out_valid stuck %b want 0", out_valid);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle(3);
    vec++;
    if ({out_valid, out_last, out_byte} !== 10'h000) begin
      miss++;
      $display("FAIL reset_out: got %b/%b/%h want 0/0/00",
               out_valid, out_last, out_byte);
    end
    vec++;
    if ({in_ready, err_len, err_chk, err_timeout, err_overrun} !== 5'b10000) begin
      miss++;
      $display("FAIL reset_flags: got %b want 10000",
               {in_ready, err_len, err_chk, err_timeout, err_overrun});
    end
    rst_n = 1'b1;
    idle(2);
  endtask

  task automatic test_good();
    logic [7:0] eb [$];
    logic       el [$];
    eb = '{8'h11, 8'h22, 8'h33};
    el = '{1'b0, 1'b0, 1'b1};
    clr();
    out_ready = 1'b1;
    tx = '{8'h7E, 8'h03, 8'h11, 8'h22, 8'h33, 8'h97};
    send_q();
    @(negedge clk);
    vec++;
    if (out_valid !== 1'b1 || out_byte !== 8'h11) begin
      miss++;
      $display("FAIL good_latency: got v=%b d=%h want v=1 d=11",
               out_valid, out_byte);
    end
    wait_drain();
    vec++;
    if (got_b.size() != 3) begin
      miss++;
      $display("FAIL good_count: got %0d want 3", got_b.size());
    end
    for (int i = 0; i < 3; i++) begin
      vec++;
      if (got_b[i] !== eb[i] || got_l[i] !== el[i]) begin
        miss++;
        $display("FAIL good_byte%0d: got %h/%b want %h/%b",
                 i, got_b[i], got_l[i], eb[i], el[i]);
      end
    end
    vec++;
    if (got_c.size() != 3 || got_c[2] - got_c[0] != 2) begin
      miss++;
      $display("FAIL good_rate: got %0d bytes not back-to-back want 3 consecutive",
               got_c.size());
    end
    vec++;
    if (n_len + n_chk + n_tmo + n_ovr != 0) begin
      miss++;
      $display("FAIL good_noerr: got %0d pulses want 0",
               n_len + n_chk + n_tmo + n_ovr);
    end
  endtask

  task automatic test_bad_chk();
    clr();
    tx = '{8'h7E, 8'h02, 8'hAA, 8'hBB, 8'h00};
    send_q();
    idle(3);
    vec++;
    if (n_chk != 1 || got_b.size() != 0 || n_len + n_tmo + n_ovr != 0) begin
      miss++;
      $display("FAIL badchk: got chk=%0d out=%0d other=%0d want 1/0/0",
               n_chk, got_b.size(), n_len + n_tmo + n_ovr);
    end
    clr();
    tx = '{8'h7E, 8'h01, 8'h5A, 8'hA5};
    send_q();
    wait_drain();
    vec++;
    if (got_b.size() != 1 || got_b[0] !== 8'h5A || got_l[0] !== 1'b1) begin
      miss++;
      $display("FAIL single: got n=%0d d=%h l=%b want 1/5a/1",
               got_b.size(), got_b[0], got_l[0]);
    end
  endtask

  task automatic test_len();
    clr();
    tx = '{8'h7E, 8'h00};
    send_q();
    idle(3);
    vec++;
    if (n_len != 1 || n_chk + n_tmo + n_ovr != 0) begin
      miss++;
      $display("FAIL len_zero: got len=%0d other=%0d want 1/0",
               n_len, n_chk + n_tmo + n_ovr);
    end
    clr();
    tx = '{8'h7E, 8'h11};
    send_q();
    idle(3);
    vec++;
    if (n_len != 1) begin
      miss++;
      $display("FAIL len_big: got %0d want 1", n_len);
    end
    clr();
    tx = '{8'h00, 8'hFF, 8'h12, 8'h7E, 8'h01, 8'h5A, 8'hA5};
    send_q();
    wait_drain();
    vec++;
    if (got_b.size() != 1 || got_b[0] !== 8'h5A || n_len + n_chk != 0) begin
      miss++;
      $display("FAIL garbage: got n=%0d d=%h err=%0d want 1/5a/0",
               got_b.size(), got_b[0], n_len + n_chk);
    end
  endtask

  task automatic test_max_len();
    int bad;
    clr();
    bad = 0;
    tx = '{8'h7E, 8'h10};
    for (int i = 1; i <= 16; i++) tx.push_back(8'(i));
    tx.push_back(8'h68);
    send_q();
    wait_drain();
    vec++;
    if (got_b.size() != 16 || n_len + n_chk != 0) begin
      miss++;
      $display("FAIL max_count: got %0d err=%0d want 16/0",
               got_b.size(), n_len + n_chk);
    end
    for (int i = 0; i < got_b.size(); i++)
      if (got_b[i] !== 8'(i + 1) || got_l[i] !== (i == 15)) bad++;
    vec++;
    if (bad != 0) begin
      miss++;
      $display("FAIL max_data: got %0d bad bytes want 0", bad);
    end
  endtask

  task automatic test_backpressure();
    int unstable;
    clr();
    unstable = 0;
    out_ready = 1'b0;
    tx = '{8'h7E, 8'h04, 8'h01, 8'h02, 8'h03, 8'h04, 8'hF2};
    send_q();
    for (int j = 0; j < 10; j++) begin
      @(negedge clk);
      in_valid = 1'b0;
      if (out_valid !== 1'b1 || out_byte !== 8'h01 || out_last !== 1'b0)
        unstable++;
      if (j == 3) begin
        vec++;
        if (in_ready !== 1'b0) begin
          miss++;
          $display("FAIL drain_ready: got %b want 0", in_ready);
        end
        in_byte  = 8'h55;
        in_valid = 1'b1;
      end
    end
    vec++;
    if (unstable != 0) begin
      miss++;
      $display("FAIL bp_hold: got %0d unstable cycles want 0", unstable);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    wait_drain();
    vec++;
    if (n_ovr != 1 || n_len + n_chk + n_tmo != 0) begin
      miss++;
      $display("FAIL overrun: got ovr=%0d other=%0d want 1/0",
               n_ovr, n_len + n_chk + n_tmo);
    end
    vec++;
    if (got_b.size() != 4 || got_b[0] !== 8'h01 || got_b[1] !== 8'h02 ||
        got_b[2] !== 8'h03 || got_b[3] !== 8'h04 || got_l[3] !== 1'b1 ||
        got_l[2] !== 1'b0) begin
      miss++;
      $display("FAIL bp_data: got n=%0d first=%h want 4 bytes 01..04",
               got_b.size(), got_b[0]);
    end
  endtask

  task automatic test_timeout();
    int k;
    clr();
    tx = '{8'h7E, 8'h03, 8'h11};
    send_q();
    for (k = 1; k <= T + 20; k++) begin
      @(posedge clk);
      #1;
      if (err_timeout) break;
    end
    vec++;
    if (k != T) begin
      miss++;
      $display("FAIL tmo_delay: got %0d cycles want %0d", k, T);
    end
    @(posedge clk);
    #1;
    vec++;
    if (err_timeout !== 1'b0) begin
      miss++;
      $display("FAIL tmo_width: got %b want 0", err_timeout);
    end
    idle(1);
    vec++;
    if (n_tmo != 1) begin
      miss++;
      $display("FAIL tmo_count: got %0d want 1", n_tmo);
    end
    clr();
    tx = '{8'h7E, 8'h02, 8'h7E, 8'h10, 8'h70};
    send_q();
    wait_drain();
    vec++;
    if (got_b.size() != 2 || got_b[0] !== 8'h7E || got_b[1] !== 8'h10 ||
        got_l[1] !== 1'b1 || n_len + n_chk + n_tmo != 0) begin
      miss++;
      $display("FAIL sof_payload: got n=%0d d0=%h want 2 bytes 7e,10",
               got_b.size(), got_b[0]);
    end
  endtask

  task automatic test_async_reset();
    clr();
    tx = '{8'h7E, 8'h04, 8'h01, 8'h02};
    send_q();
    #2;
    rst_n = 1'b0;
    #1;
    vec++;
    if ({out_valid, out_byte, in_ready} !== 10'b0_00000000_1) begin
      miss++;
      $display("FAIL rst_data: got v=%b d=%h r=%b want 0/00/1",
               out_valid, out_byte, in_ready);
    end
    idle(2);
    rst_n = 1'b1;
    out_ready = 1'b0;
    tx = '{8'h7E, 8'h04, 8'h01, 8'h02, 8'h03, 8'h04, 8'hF2};
    send_q();
    idle(2);
    vec++;
    if (out_valid !== 1'b1) begin
      miss++;
      $display("FAIL rst_pre_drain: got %b want 1", out_valid);
    end
    #2;
    rst_n = 1'b0;
    #1;
    vec++;
    if ({out_valid, out_last, out_byte} !== 10'h000) begin
      miss++;
      $display("FAIL rst_drain: got %b/%b/%h want 0/0/00",
               out_valid, out_last, out_byte);
    end
    idle(2);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    tx = '{8'h7E, 8'h03, 8'h11, 8'h22, 8'h33, 8'h97};
    send_q();
    wait_drain();
    vec++;
    if (got_b.size() != 3 || got_b[0] !== 8'h11 || got_b[2] !== 8'h33 ||
        n_len + n_chk + n_tmo + n_ovr != 0) begin
      miss++;
      $display("FAIL rst_recover: got n=%0d err=%0d want 3/0",
               got_b.size(), n_len + n_chk + n_tmo + n_ovr);
    end
  endtask

  initial begin
    test_reset();
    test_good();
    test_bad_chk();
    test_len();
    test_max_len();
    test_backpressure();
    test_timeout();
    test_async_reset();
    vec++;
    if (n_multi != 0) begin
      miss++;
      $display("FAIL err_exclusive: got %0d overlapping cycles want 0", n_multi);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
